// File: rtl/i2c_pkg.sv
// Shared types, phase constants and frame-length helper for the write-only I2C master.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    BIT   = 3'd2,
    ACK   = 3'd3,
    STOP  = 3'd4
  } state_e;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic [6:0] WM8731_ADDR = 7'h1A;

  // Quarter SCL periods from accept to done for a frame of nbytes payload bytes.
  function automatic int unsigned quarters(input int unsigned nbytes);
    return 32'd4 * (32'd2 + 32'd9 * (nbytes + 32'd1));
  endfunction

endpackage

// File: rtl/i2c_write_master_tick_gen.sv
// Quarter-period strobe generator: one-cycle qtick every CLK_DIV cycles and a 2-bit phase.
module i2c_tick_gen #(
  parameter int unsigned CLK_DIV = 5000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  output logic       qtick_o,
  output logic [1:0] phase_o
);

  localparam int unsigned CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    phase_q, phase_d;

  assign qtick_o = en_i && (cnt_q == CW'(CLK_DIV - 32'd1));
  assign phase_o = phase_q;

  // Divider and phase are held at zero whenever the master is idle.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!en_i) begin
      cnt_d   = '0;
      phase_d = 2'd0;
    end else if (qtick_o) begin
      cnt_d   = '0;
      phase_d = phase_q + 2'd1;
    end else begin
      cnt_d   = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      phase_q <= 2'd0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/i2c_write_master.sv
// Write-only I2C master: START, address+W, NBYTES payload bytes with ACK slots, STOP.
// SDA is open-drain (drive 0 or release); a NACK aborts straight to STOP.
module i2c_write_master
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 5000,
  parameter logic [6:0]  DEV_ADDR = WM8731_ADDR,
  parameter int unsigned NBYTES   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [8*NBYTES-1:0]   data,
  inout  wire                   SDIN,
  output logic                  SCLK,
  output logic                  busy,
  output logic                  done,
  output logic                  ack_error,
  output logic [NBYTES:0]       ack
);

  localparam int unsigned SRW = 8 * (NBYTES + 1);
  localparam int unsigned BCW = $clog2(NBYTES + 1);

  state_e           state_q, state_d;
  logic [SRW-1:0]   sr_q, sr_d;
  logic [3:0]       bit_q, bit_d;
  logic [BCW-1:0]   byte_q, byte_d;
  logic [NBYTES:0]  ack_q, ack_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             scl_q, scl_d;
  logic             sda_oe_q, sda_oe_d;
  logic             qtick_s;
  logic [1:0]       phase_s;
  logic             sda_in_s;

  i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_i   (clk),
    .rst_ni  (reset),
    .en_i    (state_q != IDLE),
    .qtick_o (qtick_s),
    .phase_o (phase_s)
  );

  assign sda_in_s  = SDIN;
  assign SDIN      = sda_oe_q ? 1'b0 : 1'bz;
  assign SCLK      = scl_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign ack_error = err_q;
  assign ack       = ack_q;

  // Frame sequencing; busy stays high through the done cycle so a coincident start is ignored.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    ack_d   = ack_q;
    err_d   = err_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start && !busy_q) begin
          state_d = START;
          busy_d  = 1'b1;
          sr_d    = {DEV_ADDR, 1'b0, data};
          bit_d   = 4'd0;
          byte_d  = '0;
          ack_d   = '0;
          err_d   = 1'b0;
        end
      end
      START: begin
        if (qtick_s && phase_s == Q3) state_d = BIT;
      end
      BIT: begin
        if (qtick_s && phase_s == Q3) begin
          sr_d = {sr_q[SRW-2:0], 1'b0};
          if (bit_q == 4'd7) begin
            bit_d   = 4'd0;
            state_d = ACK;
          end else begin
            bit_d   = bit_q + 4'd1;
          end
        end
      end
      ACK: begin
        if (qtick_s && phase_s == Q2) begin
          if (sda_in_s == 1'b0) ack_d[byte_q] = 1'b1;
          else                  err_d = 1'b1;
        end else if (qtick_s && phase_s == Q3) begin
          if (err_q || byte_q == BCW'(NBYTES)) begin
            state_d = STOP;
          end else begin
            byte_d  = byte_q + BCW'(1);
            state_d = BIT;
          end
        end
      end
      STOP: begin
        if (qtick_s && phase_s == Q3) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus levels per state and quarter; registered so the pads never see decode glitches.
  always_comb begin
    scl_d    = 1'b1;
    sda_oe_d = 1'b0;
    case (state_q)
      IDLE:  begin scl_d = 1'b1; sda_oe_d = 1'b0; end
      START: begin scl_d = (phase_s != Q3); sda_oe_d = (phase_s != Q0); end
      BIT:   begin scl_d = phase_s[1]; sda_oe_d = ~sr_q[SRW-1]; end
      ACK:   begin scl_d = phase_s[1]; sda_oe_d = 1'b0; end
      STOP:  begin scl_d = phase_s[1]; sda_oe_d = (phase_s != Q3); end
      default: begin scl_d = 1'b1; sda_oe_d = 1'b0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      bit_q    <= 4'd0;
      byte_q   <= '0;
      ack_q    <= '0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      scl_q    <= 1'b1;
      sda_oe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      scl_q    <= scl_d;
      sda_oe_q <= sda_oe_d;
    end
  end

endmodule

// File: tb/tb_i2c_write_master.sv
// Directed, table-driven bench for i2c_write_master with a bus-level slave/decoder model.
module tb_i2c_write_master;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned NBYTES  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] data;
  wire         sda_w;
  logic        SCLK, busy, done, ack_error;
  logic [2:0]  ack;
  logic        slave_pull = 1'b0;
  logic        force_pull = 1'b0;

  pullup (sda_w);
  assign sda_w = (slave_pull || force_pull) ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_write_master #(.CLK_DIV(CLK_DIV), .DEV_ADDR(7'h1A), .NBYTES(NBYTES)) dut (
    .clk(clk), .reset(reset), .start(start), .data(data), .SDIN(sda_w),
    .SCLK(SCLK), .busy(busy), .done(done), .ack_error(ack_error), .ack(ack)
  );

  typedef struct {
    logic [15:0] data;
    int          nack_byte;
    logic        restart;
    logic [2:0]  exp_ack;
    logic        exp_err;
    int          exp_cycles;
    int          exp_nb;
    logic [23:0] exp_bytes;
  } vec_t;

  vec_t vecs[5];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Bus observer / slave model state
  int         nack_byte = -1;
  logic [7:0] wire_bytes[$];
  int         n_start = 0, n_stop = 0, n_hi = 0, n_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave: ACKs every byte except nack_byte; decodes bytes and counts SDA edges while SCL high.
  initial begin
    logic prev_scl, prev_sda, in_frame, scl_v, sda_v;
    logic [7:0] sh;
    int bitn, byte_idx;
    prev_scl = 1'b1; prev_sda = 1'b1; in_frame = 1'b0; sh = 8'h00; bitn = 0; byte_idx = 0;
    forever begin
      @(negedge clk);
      scl_v = SCLK;
      sda_v = sda_w;
      if (done) n_done++;
      if (reset !== 1'b1) begin
        in_frame = 1'b0; slave_pull = 1'b0; bitn = 0; byte_idx = 0;
      end else if (prev_scl && scl_v && (prev_sda != sda_v)) begin
        n_hi++;
        if (!sda_v) begin n_start++; in_frame = 1'b1; bitn = 0; byte_idx = 0; end
        else begin n_stop++; in_frame = 1'b0; slave_pull = 1'b0; end
      end else if (in_frame && !prev_scl && scl_v) begin
        if (bitn < 8) begin
          sh = {sh[6:0], sda_v};
          bitn++;
          if (bitn == 8) wire_bytes.push_back(sh);
        end else begin
          bitn = 0;
          byte_idx++;
        end
      end else if (in_frame && prev_scl && !scl_v) begin
        slave_pull = (bitn == 8) && (byte_idx != nack_byte);
      end
      prev_scl = scl_v;
      prev_sda = sda_v;
    end
  end

  task automatic run_frame(input vec_t v, input int idx);
    int k;
    logic got;
    logic [31:0] b;
    nack_byte = v.nack_byte;
    wire_bytes.delete();
    n_start = 0; n_stop = 0; n_hi = 0; n_done = 0;
    @(negedge clk);
    data  = v.data;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d busy_after_accept", idx), 32'(busy), 32'd1);
    k = 0;
    got = 1'b0;
    while (!got && k < 3000) begin
      @(posedge clk);
      k++;
      @(negedge clk);
      if (v.restart && k == 40) begin start = 1'b1; data = 16'h1234; end
      else if (k == 41) start = 1'b0;
      if (done) got = 1'b1;
    end
    chk($sformatf("v%0d done_seen", idx), 32'(got), 32'd1);
    chk($sformatf("v%0d done_latency", idx), 32'(k), 32'(v.exp_cycles));
    chk($sformatf("v%0d ack", idx), 32'(ack), 32'(v.exp_ack));
    chk($sformatf("v%0d ack_error", idx), 32'(ack_error), 32'(v.exp_err));
    chk($sformatf("v%0d busy_in_done_cycle", idx), 32'(busy), 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk($sformatf("v%0d busy_after_done", idx), 32'(busy), 32'd0);
    chk($sformatf("v%0d done_one_cycle", idx), 32'(done), 32'd0);
    repeat (8) @(negedge clk);
    chk($sformatf("v%0d start_at_done_ignored", idx), 32'(busy), 32'd0);
    chk($sformatf("v%0d done_pulses", idx), 32'(n_done), 32'd1);
    chk($sformatf("v%0d scl_idle", idx), 32'(SCLK), 32'd1);
    chk($sformatf("v%0d bytes_on_wire", idx), 32'(wire_bytes.size()), 32'(v.exp_nb));
    for (int i = 0; i < v.exp_nb; i++) begin
      b = (i < wire_bytes.size()) ? 32'(wire_bytes[i]) : 32'hDEAD;
      chk($sformatf("v%0d byte%0d", idx, i), b, 32'(v.exp_bytes[23-8*i -: 8]));
    end
    chk($sformatf("v%0d start_cond", idx), 32'(n_start), 32'd1);
    chk($sformatf("v%0d stop_cond", idx), 32'(n_stop), 32'd1);
    chk($sformatf("v%0d sda_edges_scl_high", idx), 32'(n_hi), 32'd2);
  endtask

  initial begin
    vecs[0] = '{data: 16'h1E00, nack_byte: -1, restart: 1'b0, exp_ack: 3'b111, exp_err: 1'b0,
                exp_cycles: 464, exp_nb: 3, exp_bytes: 24'h341E00};
    vecs[1] = '{data: 16'hA55A, nack_byte: 0, restart: 1'b0, exp_ack: 3'b000, exp_err: 1'b1,
                exp_cycles: 176, exp_nb: 1, exp_bytes: 24'h340000};
    vecs[2] = '{data: 16'hC3F1, nack_byte: 1, restart: 1'b0, exp_ack: 3'b001, exp_err: 1'b1,
                exp_cycles: 320, exp_nb: 2, exp_bytes: 24'h34C300};
    vecs[3] = '{data: 16'hFFFF, nack_byte: 2, restart: 1'b0, exp_ack: 3'b011, exp_err: 1'b1,
                exp_cycles: 464, exp_nb: 3, exp_bytes: 24'h34FFFF};
    vecs[4] = '{data: 16'h8001, nack_byte: -1, restart: 1'b1, exp_ack: 3'b111, exp_err: 1'b0,
                exp_cycles: 464, exp_nb: 3, exp_bytes: 24'h348001};

    reset = 1'b0;
    start = 1'b0;
    data  = 16'h0000;
    repeat (3) @(negedge clk);
    chk("reset scl", 32'(SCLK), 32'd1);
    chk("reset sda_released", 32'(sda_w), 32'd1);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset ack", 32'(ack), 32'd0);
    chk("reset ack_error", 32'(ack_error), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // In IDLE the master must only release SDA, so an external pull-down wins.
    force_pull = 1'b1;
    #1 chk("idle sda_pulled_low", 32'(sda_w), 32'd0);
    force_pull = 1'b0;
    #1 chk("idle sda_released", 32'(sda_w), 32'd1);

    for (int i = 0; i < 5; i++) run_frame(vecs[i], i);

    // Reset in quarter 50 of a frame, then a clean frame afterwards.
    nack_byte = -1;
    @(negedge clk);
    data  = 16'h5AC3;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (200) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("midreset scl", 32'(SCLK), 32'd1);
    chk("midreset sda_released", 32'(sda_w), 32'd1);
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset done", 32'(done), 32'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    run_frame(vecs[0], 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
